// File: rtl/tx_jesd204b_pkg.sv
// rtl/tx_jesd204b_pkg.sv - shared JESD204B transmit constants, link state type and FCHK helper
package tx_jesd204b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } link_state_t;

  // Mod-256 sum of the 13 ILAS configuration octets.
  function automatic logic [7:0] fchk(input logic [103:0] cfg);
    logic [7:0] sum;
    sum = 8'd0;
    for (int n = 0; n < 13; n++) begin
      sum = sum + cfg[8*n +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/tx_lmfc_counter.sv
// rtl/tx_lmfc_counter.sv - free-running local multiframe counter with boundary pulse
module tx_lmfc_counter #(
  parameter int FK = 32
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lmfc_cnt,
  output logic       lmfc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lmfc_cnt <= 8'd0;
    end else if (lmfc_cnt == 8'(FK - 1)) begin
      lmfc_cnt <= 8'd0;
    end else begin
      lmfc_cnt <= lmfc_cnt + 8'd1;
    end
  end

  // Held low while in reset so the pulse only marks live boundaries.
  assign lmfc = ~rst & (lmfc_cnt == 8'd0);

endmodule

// File: rtl/tx_link_ctrl.sv
// rtl/tx_link_ctrl.sv - CGS/ILAS/DATA sequencer feeding a single-lane JESD204B link layer
module tx_link_ctrl
  import tx_jesd204b_pkg::*;
#(
  parameter int F = 1,
  parameter int K = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync_n,
  input  logic [103:0] cfg_ilas,
  input  logic [7:0]   s_data,
  input  logic         s_vld,
  output logic         s_rdy,
  output logic [7:0]   o_data,
  output logic         o_k,
  output logic         o_vld,
  output logic [1:0]   o_state,
  output logic         o_lmfc
);

  localparam int FK = F * K;

  if (F < 1 || F > 4 || FK < 17 || FK > 256) begin : g_bad_cfg
    $error("tx_link_ctrl: F must be 1..4 and F*K must be 17..256");
  end

  link_state_t   state, state_nxt;
  logic [1:0]    mf, mf_nxt;
  logic [1:0]    low, low_nxt;
  logic [103:0]  cfg_q;
  logic [7:0]    cnt;
  logic          last, resync;
  logic [3:0]    oct_idx;
  logic [7:0]    ilas_data;
  logic          ilas_k;
  logic [7:0]    data_nxt;
  logic          k_nxt, vld_nxt;

  tx_lmfc_counter #(.FK(FK)) u_lmfc (
    .clk      (clk),
    .rst      (rst),
    .lmfc_cnt (cnt),
    .lmfc     (o_lmfc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_CGS;
      mf     <= 2'd0;
      low    <= 2'd0;
      cfg_q  <= '0;
      o_data <= 8'd0;
      o_k    <= 1'b0;
      o_vld  <= 1'b0;
    end else begin
      state  <= state_nxt;
      mf     <= mf_nxt;
      low    <= low_nxt;
      o_data <= data_nxt;
      o_k    <= k_nxt;
      o_vld  <= vld_nxt;
      if (state == ST_ILAS && mf == 2'd0 && cnt == 8'd0) begin
        cfg_q <= cfg_ilas;
      end
    end
  end

  assign oct_idx = 4'(cnt - 8'd2);

  always_comb begin
    last      = (cnt == 8'(FK - 1));
    resync    = (state != ST_CGS) && !sync_n && (low == 2'd3);
    state_nxt = state;
    mf_nxt    = mf;
    low_nxt   = 2'd0;
    ilas_data = cnt;
    ilas_k    = 1'b0;
    data_nxt  = 8'd0;
    k_nxt     = 1'b0;
    vld_nxt   = 1'b0;

    if (state != ST_CGS && !sync_n && low != 2'd3) begin
      low_nxt = low + 2'd1;
    end

    unique case (state)
      ST_CGS: begin
        mf_nxt = 2'd0;
        if (sync_n && last) state_nxt = ST_ILAS;
      end
      ST_ILAS: begin
        if (last) begin
          mf_nxt = mf + 2'd1;
          if (mf == 2'd3) state_nxt = ST_DATA;
        end
      end
      ST_DATA: ;
      default: state_nxt = ST_CGS;
    endcase

    // Loss of sync overrides everything, including the ILAS-to-DATA step.
    if (resync) begin
      state_nxt = ST_CGS;
      mf_nxt    = 2'd0;
    end

    if (cnt == 8'd0) begin
      ilas_data = K28_0;
      ilas_k    = 1'b1;
    end else if (last) begin
      ilas_data = K28_3;
      ilas_k    = 1'b1;
    end else if (mf == 2'd1) begin
      if (cnt == 8'd1) begin
        ilas_data = K28_4;
        ilas_k    = 1'b1;
      end else if (cnt <= 8'd14) begin
        ilas_data = cfg_q[8*int'(oct_idx) +: 8];
      end else if (cnt == 8'd15) begin
        ilas_data = fchk(cfg_q);
      end
    end

    if (state == ST_CGS || resync) begin
      data_nxt = K28_5;
      k_nxt    = 1'b1;
      vld_nxt  = 1'b1;
    end else if (state == ST_ILAS) begin
      data_nxt = ilas_data;
      k_nxt    = ilas_k;
      vld_nxt  = 1'b1;
    end else if (state == ST_DATA) begin
      data_nxt = s_vld ? s_data : 8'd0;
      vld_nxt  = s_vld;
    end
  end

  assign s_rdy   = (state == ST_DATA);
  assign o_state = state;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// tb/tb_tx_link_ctrl.sv - self-checking bench for tx_link_ctrl
module tb_tx_link_ctrl;

  localparam int F_T  = 1;
  localparam int K_T  = 32;
  localparam int FK   = F_T * K_T;

  logic         clk = 1'b0;
  logic         rst;
  logic         sync_n;
  logic [103:0] cfg_ilas;
  logic [7:0]   s_data;
  logic         s_vld;
  logic         s_rdy;
  logic [7:0]   o_data;
  logic         o_k;
  logic         o_vld;
  logic [1:0]   o_state;
  logic         o_lmfc;

  tx_link_ctrl #(.F(F_T), .K(K_T)) dut (
    .clk      (clk),
    .rst      (rst),
    .sync_n   (sync_n),
    .cfg_ilas (cfg_ilas),
    .s_data   (s_data),
    .s_vld    (s_vld),
    .s_rdy    (s_rdy),
    .o_data   (o_data),
    .o_k      (o_k),
    .o_vld    (o_vld),
    .o_state  (o_state),
    .o_lmfc   (o_lmfc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=CGS 1=ILAS 2=DATA, position counted across the whole ILAS.
  int           m_cnt = 0;
  int           m_phase = 0;
  int           m_pos = 0;
  int           m_run = 0;
  logic [103:0] m_cfg = '0;
  logic [7:0]   e_data = 8'd0;
  logic         e_k = 1'b0;
  logic         e_vld = 1'b0;
  logic [1:0]   last_state = 2'd0;
  logic [7:0]   q[$];

  typedef struct {
    logic       sync_n;
    logic       vld;
    logic [7:0] data;
    logic [7:0] x_data;
    logic       x_k;
    logic       x_vld;
    logic       x_rdy;
    logic [1:0] x_state;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fchk_ref(input logic [103:0] c);
    int s;
    s = 0;
    for (int n = 0; n < 13; n++) s += int'(c[8*n +: 8]);
    return 8'(s % 256);
  endfunction

  task automatic model_step();
    int  i, m;
    bit  bad;
    if (rst) begin
      m_cnt = 0; m_phase = 0; m_run = 0;
      e_data = 8'd0; e_k = 1'b0; e_vld = 1'b0;
      return;
    end
    bad = (m_phase != 0) && !sync_n && (m_run >= 3);
    if (m_phase == 0 || bad) begin
      e_data = 8'hBC; e_k = 1'b1; e_vld = 1'b1;
    end else if (m_phase == 1) begin
      if (m_pos == 0) m_cfg = cfg_ilas;
      m = m_pos / FK;
      i = m_pos % FK;
      e_vld = 1'b1; e_k = 1'b0; e_data = 8'(i);
      if (i == 0) begin e_data = 8'h1C; e_k = 1'b1; end
      else if (i == FK - 1) begin e_data = 8'h7C; e_k = 1'b1; end
      else if (m == 1 && i == 1) begin e_data = 8'h9C; e_k = 1'b1; end
      else if (m == 1 && i >= 2 && i <= 14) e_data = m_cfg[8*(i-2) +: 8];
      else if (m == 1 && i == 15) e_data = fchk_ref(m_cfg);
    end else begin
      e_k = 1'b0; e_vld = s_vld; e_data = s_vld ? s_data : 8'd0;
    end
    m_run = (m_phase == 0 || sync_n || bad) ? 0 : m_run + 1;
    if (bad) m_phase = 0;
    else if (m_phase == 0 && sync_n && m_cnt == FK - 1) begin m_phase = 1; m_pos = 0; end
    else if (m_phase == 1) begin
      m_pos++;
      if (m_pos == 4 * FK) m_phase = 2;
    end
    m_cnt = (m_cnt + 1) % FK;
  endtask

  task automatic step();
    last_state = o_state;
    model_step();
    @(posedge clk);
    #1;
    chk("o_data", int'(o_data), int'(e_data));
    chk("o_k", int'(o_k), int'(e_k));
    chk("o_vld", int'(o_vld), int'(e_vld));
    chk("o_state", int'(o_state), m_phase);
    chk("s_rdy", int'(s_rdy), int'(m_phase == 2));
    chk("o_lmfc", int'(o_lmfc), int'(!rst && m_cnt == 0));
  endtask

  task automatic capture_ilas();
    int n;
    q.delete();
    n = 0;
    while (o_state == 2'd1 && n < 400) begin
      step();
      if (last_state == 2'd1) q.push_back(o_data);
      n++;
    end
    chk("ilas_len", q.size(), 4 * FK);
    while (q.size() < 4 * FK) q.push_back(8'h00);
  endtask

  task automatic count_cgs(input string nm, input int exp);
    int n;
    n = 0;
    while (o_state == 2'd0 && n < 3 * FK) begin
      step();
      n++;
    end
    chk(nm, n, exp);
  endtask

  initial begin
    rst = 1'b1; sync_n = 1'b0; s_vld = 1'b0; s_data = 8'd0; cfg_ilas = '0;
    for (int n = 0; n < 13; n++) cfg_ilas[8*n +: 8] = 8'(n + 1);

    // Reset then CGS
    for (int n = 0; n < 3; n++) step();
    chk("rst_data", int'(o_data), 0);
    chk("rst_state", int'(o_state), 0);
    rst = 1'b0;
    step();
    chk("cgs_first", int'(o_data), 'hBC);
    for (int n = 0; n < 5; n++) step();
    chk("cgs_k", int'(o_k), 1);
    chk("cgs_rdy", int'(s_rdy), 0);

    // ILAS layout, sync raised at lmfc_cnt == 10
    for (int n = 0; n < 2 * FK && m_cnt != 10; n++) step();
    sync_n = 1'b1;
    count_cgs("wait_to_boundary", FK - 10);
    capture_ilas();
    chk("ilas_r0", q[0], 'h1C);   chk("ilas_5", q[5], 'h05);
    chk("ilas_a0", q[31], 'h7C);  chk("ilas_r1", q[32], 'h1C);
    chk("ilas_q", q[33], 'h9C);   chk("ilas_cfg0", q[34], 'h01);
    chk("ilas_cfg12", q[46], 'h0D); chk("ilas_fchk", q[47], 'h5B);
    chk("ilas_16", q[48], 'h10);  chk("ilas_a2", q[95], 'h7C);
    chk("ilas_r3", q[96], 'h1C);  chk("ilas_a3", q[127], 'h7C);

    // Data passthrough, glitch rejection and resync
    tbl[0]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[1]  = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[2]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[3]  = '{1'b1, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[4]  = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[5]  = '{1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[6]  = '{1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[7]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[8]  = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[9]  = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[10] = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b1, 2'd2};
    tbl[11] = '{1'b0, 1'b1, 8'hA5, 8'hBC, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 1'b1, 8'hA5, 8'hBC, 1'b1, 1'b1, 1'b0, 2'd0};
    for (int r = 0; r < 13; r++) begin
      sync_n = tbl[r].sync_n; s_vld = tbl[r].vld; s_data = tbl[r].data;
      step();
      chk($sformatf("tbl%0d_data", r), int'(o_data), int'(tbl[r].x_data));
      chk($sformatf("tbl%0d_k", r), int'(o_k), int'(tbl[r].x_k));
      chk($sformatf("tbl%0d_vld", r), int'(o_vld), int'(tbl[r].x_vld));
      chk($sformatf("tbl%0d_rdy", r), int'(s_rdy), int'(tbl[r].x_rdy));
      chk($sformatf("tbl%0d_state", r), int'(o_state), int'(tbl[r].x_state));
    end
    s_vld = 1'b0;

    // Boundary wait: rise at FK-1, then rise at 0
    rst = 1'b1; sync_n = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int n = 0; n < 2 * FK && m_cnt != FK - 1; n++) step();
    sync_n = 1'b1;
    step();
    chk("bw_ilas_now", int'(o_state), 1);
    step();
    chk("bw_r_next", int'(o_data), 'h1C);
    rst = 1'b1; sync_n = 1'b0;
    step(); step();
    rst = 1'b0; sync_n = 1'b1;
    count_cgs("bw_full_mf", FK);

    // Reset mid-ILAS at m=2
    for (int n = 0; n < 4 * FK && !(m_phase == 1 && m_pos / FK == 2); n++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_state", int'(o_state), 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_lmfc0", int'(o_lmfc), 1);
    count_cgs("mid_rst_wait", FK);
    capture_ilas();
    chk("mid_rst_r0", q[0], 'h1C);
    chk("mid_rst_q", q[33], 'h9C);

    // Randomised run against the model
    begin
      int run_left;
      run_left = 0;
      for (int n = 0; n < 4000; n++) begin
        rst = ($urandom_range(0, 599) == 0);
        if (run_left == 0) begin
          sync_n   = ($urandom_range(0, 9) < 7);
          run_left = sync_n ? int'($urandom_range(1, 150)) : int'($urandom_range(1, 6));
        end
        run_left--;
        s_vld  = 1'($urandom_range(0, 1));
        s_data = 8'($urandom);
        if ($urandom_range(0, 49) == 0) cfg_ilas = 104'({$urandom, $urandom, $urandom, $urandom});
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_link_ctrl.md
# tx_link_ctrl

Link-layer sequencer in front of `tx_link_layer` for a single JESD204B transmit lane at one octet per `clk`. It drives the Code Group Synchronization (CGS), Initial Lane Alignment Sequence (ILAS) and user-data phases in response to the receiver's `sync_n`. It produces the octet/K/valid stream that feeds `tx_link_layer` inputs `i_data`/`i_k`/`i_vld`, and applies ready-handshake backpressure to the user data source.

## Interface
- `F`, default 1: octets per frame; legal values 1..4.
- `K`, default 32: frames per multiframe. `FK = F*K` must satisfy 17 ≤ FK ≤ 256; violation is an elaboration error.
- `clk` in 1: device clock, 125 MHz, one octet per cycle.
- `rst` in 1: synchronous, active-high reset.
- `sync_n` in 1: receiver SYNC~, active-low; already synchronous to `clk`.
- `cfg_ilas` in 104: ILAS config octets 0..12; octet n sits in bits [8n+7:8n].
- `s_data` in 8: user octet.
- `s_vld` in 1: user octet valid.
- `s_rdy` out 1: block accepts `s_data`. Equals (state==DATA), decoded from the state register.
- `o_data` out 8: octet to link layer; registered.
- `o_k` out 1: `o_data` is a control character; registered.
- `o_vld` out 1: `o_data` valid; registered.
- `o_state` out 2: CGS=0, ILAS=1, DATA=2.
- `o_lmfc` out 1: one-cycle pulse when `lmfc_cnt==0`.

## Operation
- `lmfc_cnt` is 8 bits and free-running.
  - It counts 0..FK-1 and wraps.
  - It is cleared only by `rst`. State changes never reset it.
- **CGS:** each cycle outputs K28.5: `o_data`=0xBC, `o_k`=1, `o_vld`=1.
  - Once `sync_n` is sampled high, the block waits for the next `lmfc_cnt==0`. That cycle is ILAS octet 0.
  - If `sync_n` falls again before that boundary, the block stays in CGS.
- **ILAS:** 4 multiframes, indexed m=0..3. Octet index i equals `lmfc_cnt`.
  - i=0 → /R/ 0x1C, k=1.
  - i=FK-1 → /A/ 0x7C, k=1.
  - m=1, i=1 → /Q/ 0x9C, k=1.
  - m=1, i=2..14 → `cfg_ilas` octet i-2, k=0.
  - m=1, i=15 → FCHK = (sum of cfg octets 0..12) mod 256, k=0.
  - All other positions → i[7:0], k=0.
  - `o_vld`=1 throughout ILAS.
  - `cfg_ilas` is sampled on the first ILAS cycle and held until ILAS ends.
- **DATA:** entered at the boundary immediately after m=3, i=FK-1.
  - If `s_vld`=1: `o_data`=`s_data`, `o_k`=0, `o_vld`=1.
  - If `s_vld`=0: `o_data`=0x00, `o_k`=0, `o_vld`=0.
- **Resync:** applies in ILAS or DATA.
  - A 2-bit saturating counter counts consecutive low samples of `sync_n`; any high sample clears it.
  - On the 4th consecutive low sample, the state becomes CGS on the next edge.
  - `s_rdy` drops in the same cycle the state changes.
  - Fewer than 4 low samples are ignored.
- **Reset:** `rst` mid-operation forces CGS on the next edge from any state.

## Timing
- Reset values:
  - `o_data`=0x00, `o_k`=0, `o_vld`=0
  - `o_state`=CGS, `s_rdy`=0, `o_lmfc`=0
  - `lmfc_cnt`=0, multiframe counter=0, low counter=0
- The first CGS character appears on `o_data` one cycle after `rst` deasserts.
- Output latency is 1 cycle: the octet for `lmfc_cnt`=i appears on `o_data` the cycle after the counter equals i. This applies to ILAS and to `s_data` in DATA alike.
- A `s_data` beat is accepted when `s_vld`&&`s_rdy`; there is no skid buffer.
- ILAS duration is exactly 4·FK cycles.
- Simultaneous events resolve in this priority: `rst` > resync > `sync_n` rise.
- The 4th low sample landing on the last ILAS octet still returns to CGS, not DATA.

## Structure
- Shared package `tx_jesd204b_pkg` contains:
  - constants K28_5=0xBC, K28_0=0x1C, K28_3=0x7C, K28_4=0x9C
  - the 2-bit state typedef and its encodings
  - the FCHK function
- One sub-module, `tx_lmfc_counter`: parameter FK; outputs `lmfc_cnt` and the `lmfc` pulse. It is reused later by the receiver side.
- The FSM, ILAS mux and output registers live in `tx_link_ctrl`.

## Test plan
- **Reset then CGS:** `rst` high 3 cycles, `sync_n`=0 → `o_data`=0xBC, `o_k`=1 every cycle; `s_rdy`=0.
- **ILAS layout:** F=1, K=32, `cfg_ilas` octets 0..12 = 0x01..0x0D; raise `sync_n` at `lmfc_cnt`=10. Required response:
  - /R/ appears at the next boundary.
  - m=1 shows 0x1C, 0x9C, 0x01..0x0D, FCHK=0x5B.
  - Each multiframe ends in 0x7C; 128 ILAS cycles total.
- **Data passthrough:** after ILAS, drive `s_data`=0xA5 with `s_vld` toggling.
  - `o_data`=0xA5, `o_vld`=1 one cycle after each accepted beat.
  - `o_vld`=0 on idle cycles.
- **Glitch rejection:** in DATA, `sync_n` low for 3 cycles → state stays DATA. Low for 4 cycles → 0xBC on `o_data` and `s_rdy`=0 the cycle after the 4th.
- **Boundary wait:** `sync_n` rises at `lmfc_cnt`=FK-1 → ILAS /R/ is output the next cycle. `sync_n` rises at `lmfc_cnt`=0 → CGS continues for FK more cycles.
- **Reset mid-ILAS:** assert `rst` at m=2 → CGS resumes, `lmfc_cnt`=0, and the next ILAS starts again from m=0.
